freelist_multiport: RTL and testbench

- Physical-register free list for the rename stage, supporting ALLOC_WIDTH allocations and RELEASE_WIDTH releases per cycle.
- Allocations are speculative. A commit pointer tracks retired allocations, so a pipeline flush restores the speculative read pointer in one cycle.
- p0 is never held. The list holds pregs 1..DEPTH, where DEPTH = PREG_NUM-1.
- Sits between decode/rename (allocate), ROB commit (commit count, release) and the flush controller.

---
 rtl/freelist_multiport_pkg.sv | 30 +++
 rtl/freelist_ptr_unit.sv | 38 +++
 rtl/freelist_multiport.sv | 149 ++++++++++++++
 tb/tb_freelist_multiport.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/freelist_multiport_pkg.sv
// Shared rename-stage definitions for the physical-register free list.
// Holds the register-file geometry, the derived widths used by the list,
// common typedefs and the modulo-DEPTH pointer adder.
package freelist_multiport_pkg;

   localparam int unsigned PREG_NUM        = 64;
   localparam int unsigned PREG_WIDTH      = $clog2(PREG_NUM);
   localparam int unsigned ALLOC_WIDTH     = 2;
   localparam int unsigned RELEASE_WIDTH   = 2;

   // p0 is never on the list, so the queue holds pregs 1..PREG_NUM-1.
   localparam int unsigned DEPTH           = PREG_NUM - 1;
   localparam int unsigned CNT_WIDTH       = PREG_WIDTH + 1;
   localparam int unsigned PTR_WIDTH       = $clog2(DEPTH);
   localparam int unsigned COMMIT_WIDTH    = $clog2(ALLOC_WIDTH + 1);
   localparam int unsigned REL_CNT_WIDTH   = $clog2(RELEASE_WIDTH + 1);

   typedef logic [PREG_WIDTH-1:0] preg_t;
   typedef logic [PTR_WIDTH-1:0]  ptr_t;
   typedef logic [CNT_WIDTH-1:0]  cnt_t;

   // Modulo-DEPTH add; DEPTH need not be a power of two. Valid for inc <= DEPTH.
   function automatic ptr_t ptr_add(ptr_t ptr, int unsigned inc);
      int unsigned sum;
      sum = 32'(ptr) + inc;
      if (sum >= DEPTH) sum = sum - DEPTH;
      return ptr_t'(sum);
   endfunction

endpackage

// File: rtl/freelist_ptr_unit.sv
// Modulo-DEPTH queue pointer with a variable per-cycle increment and a
// synchronous load that overrides the increment.
// Ports:
//   clk        - clock
//   rst        - synchronous active-low reset, pointer returns to 0
//   inc_i      - amount to advance this cycle
//   load_i     - replace the pointer with load_val_i at the next edge
//   load_val_i - value loaded when load_i is set
//   ptr_o      - current pointer
module freelist_ptr_unit
   import freelist_multiport_pkg::*;
#(
   parameter int unsigned IncWidth = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [IncWidth-1:0] inc_i,
   input  logic                load_i,
   input  ptr_t                load_val_i,
   output ptr_t                ptr_o
);

   ptr_t ptr_q, ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (load_i) ptr_d = load_val_i;
      else        ptr_d = ptr_add(ptr_q, 32'(inc_i));
   end

   always_ff @(posedge clk) begin
      if (!rst) ptr_q <= '0;
      else      ptr_q <= ptr_d;
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/freelist_multiport.sv
// Physical-register free list for rename. Hands out up to ALLOC_WIDTH pregs per
// cycle speculatively and accepts up to RELEASE_WIDTH released pregs per cycle.
// A committed pointer/count pair shadows the speculative read side so a flush
// rewinds all uncommitted allocations in one cycle.
// Ports:
//   clk, rst        - clock, synchronous active-low reset
//   alloc_req_i     - per-lane allocate request (lanes may be sparse)
//   alloc_gnt_o     - every requested lane granted (all-or-nothing)
//   alloc_preg_o    - preg per lane, lane k at [k*PREG_WIDTH +: PREG_WIDTH]
//   release_vld_i   - per-lane release valid
//   release_preg_i  - released preg per lane
//   commit_cnt_i    - allocations retired this cycle
//   flush_i         - squash uncommitted allocations
//   free_num_o      - speculative free count
//   empty_o, full_o - free count is 0 / DEPTH
//   overflow_err_o  - sticky: a release was dropped because the list was full
module freelist_multiport
   import freelist_multiport_pkg::*;
(
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [ALLOC_WIDTH-1:0]               alloc_req_i,
   output logic                                 alloc_gnt_o,
   output logic [ALLOC_WIDTH*PREG_WIDTH-1:0]    alloc_preg_o,
   input  logic [RELEASE_WIDTH-1:0]             release_vld_i,
   input  logic [RELEASE_WIDTH*PREG_WIDTH-1:0]  release_preg_i,
   input  logic [COMMIT_WIDTH-1:0]              commit_cnt_i,
   input  logic                                 flush_i,
   output logic [CNT_WIDTH-1:0]                 free_num_o,
   output logic                                 empty_o,
   output logic                                 full_o,
   output logic                                 overflow_err_o
);

   preg_t queue_q [DEPTH];

   ptr_t rd_ptr, cmt_ptr, wr_ptr, cmt_ptr_next;
   cnt_t spec_cnt_q, spec_cnt_d, cmt_cnt_q, cmt_cnt_d;
   logic overflow_q, overflow_d;

   int unsigned n_req, n_acc, room;
   logic                       rel_drop;
   logic [RELEASE_WIDTH-1:0]   wr_en;
   ptr_t                       wr_idx  [RELEASE_WIDTH];
   preg_t                      wr_data [RELEASE_WIDTH];
   logic [COMMIT_WIDTH-1:0]    rd_inc;
   logic [REL_CNT_WIDTH-1:0]   wr_inc;

   // Lane k reads the entry offset by the number of requesting lanes below it.
   always_comb begin
      n_req        = 0;
      alloc_preg_o = '0;
      for (int k = 0; k < ALLOC_WIDTH; k++) begin
         alloc_preg_o[k*PREG_WIDTH +: PREG_WIDTH] = queue_q[ptr_add(rd_ptr, n_req)];
         if (alloc_req_i[k]) n_req = n_req + 1;
      end
   end

   assign alloc_gnt_o = !flush_i && (n_req <= 32'(spec_cnt_q));

   // Compact valid release lanes; lanes beyond the free room (highest first) drop.
   always_comb begin
      n_acc    = 0;
      rel_drop = 1'b0;
      wr_en    = '0;
      room     = DEPTH - 32'(spec_cnt_q);
      for (int l = 0; l < RELEASE_WIDTH; l++) begin
         wr_idx[l]  = '0;
         wr_data[l] = '0;
         if (release_vld_i[l]) begin
            if (n_acc < room) begin
               wr_en[l]   = 1'b1;
               wr_idx[l]  = ptr_add(wr_ptr, n_acc);
               wr_data[l] = release_preg_i[l*PREG_WIDTH +: PREG_WIDTH];
               n_acc      = n_acc + 1;
            end else begin
               rel_drop = 1'b1;
            end
         end
      end
   end

   always_comb begin
      rd_inc       = alloc_gnt_o ? COMMIT_WIDTH'(n_req) : '0;
      wr_inc       = REL_CNT_WIDTH'(n_acc);
      cmt_ptr_next = ptr_add(cmt_ptr, 32'(commit_cnt_i));
      cmt_cnt_d    = cnt_t'(32'(cmt_cnt_q) + n_acc - 32'(commit_cnt_i));
      spec_cnt_d   = cnt_t'(32'(spec_cnt_q) + n_acc - (alloc_gnt_o ? n_req : 0));
      // Flush rewinds to the committed image, including this cycle's release/commit.
      if (flush_i) spec_cnt_d = cmt_cnt_d;
      overflow_d   = overflow_q | rel_drop;
   end

   freelist_ptr_unit #(.IncWidth(COMMIT_WIDTH)) u_rd_ptr (
      .clk        (clk),
      .rst        (rst),
      .inc_i      (rd_inc),
      .load_i     (flush_i),
      .load_val_i (cmt_ptr_next),
      .ptr_o      (rd_ptr)
   );

   freelist_ptr_unit #(.IncWidth(COMMIT_WIDTH)) u_cmt_ptr (
      .clk        (clk),
      .rst        (rst),
      .inc_i      (commit_cnt_i),
      .load_i     (1'b0),
      .load_val_i ('0),
      .ptr_o      (cmt_ptr)
   );

   freelist_ptr_unit #(.IncWidth(REL_CNT_WIDTH)) u_wr_ptr (
      .clk        (clk),
      .rst        (rst),
      .inc_i      (wr_inc),
      .load_i     (1'b0),
      .load_val_i ('0),
      .ptr_o      (wr_ptr)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) queue_q[i] <= preg_t'(i + 1);
         spec_cnt_q <= cnt_t'(DEPTH);
         cmt_cnt_q  <= cnt_t'(DEPTH);
         overflow_q <= 1'b0;
      end else begin
         for (int l = 0; l < RELEASE_WIDTH; l++) begin
            if (wr_en[l]) queue_q[wr_idx[l]] <= wr_data[l];
         end
         spec_cnt_q <= spec_cnt_d;
         cmt_cnt_q  <= cmt_cnt_d;
         overflow_q <= overflow_d;
      end
   end

   assign free_num_o     = spec_cnt_q;
   assign empty_o        = (spec_cnt_q == '0);
   assign full_o         = (spec_cnt_q == cnt_t'(DEPTH));
   assign overflow_err_o = overflow_q;

`ifndef SYNTHESIS
   // Callers may only retire allocations that are still outstanding.
   always_ff @(posedge clk) begin
      if (rst) assert (32'(commit_cnt_i) <= 32'(cmt_cnt_q) - 32'(spec_cnt_q));
   end
`endif

endmodule

// File: tb/tb_freelist_multiport.sv
module tb_freelist_multiport;

   localparam int PW = 6;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  alloc_req_i;
   logic        alloc_gnt_o;
   logic [11:0] alloc_preg_o;
   logic [1:0]  release_vld_i;
   logic [11:0] release_preg_i;
   logic [1:0]  commit_cnt_i;
   logic        flush_i;
   logic [6:0]  free_num_o;
   logic        empty_o, full_o, overflow_err_o;

   int checks = 0;
   int errors = 0;

   freelist_multiport dut (
      .clk            (clk),
      .rst            (rst),
      .alloc_req_i    (alloc_req_i),
      .alloc_gnt_o    (alloc_gnt_o),
      .alloc_preg_o   (alloc_preg_o),
      .release_vld_i  (release_vld_i),
      .release_preg_i (release_preg_i),
      .commit_cnt_i   (commit_cnt_i),
      .flush_i        (flush_i),
      .free_num_o     (free_num_o),
      .empty_o        (empty_o),
      .full_o         (full_o),
      .overflow_err_o (overflow_err_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alloc_req_i    = 2'b00;
      release_vld_i  = 2'b00;
      release_preg_i = '0;
      commit_cnt_i   = 2'd0;
      flush_i        = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
   endtask

   function automatic logic [5:0] lane(input logic [11:0] v, input int k);
      return v[k*PW +: PW];
   endfunction

   task automatic test_reset();
      do_reset();
      checks++; if (free_num_o !== 7'd63) begin errors++;
         $display("FAIL reset_free_num got %0d want 63", free_num_o); end
      checks++; if (full_o !== 1'b1) begin errors++;
         $display("FAIL reset_full got %b want 1", full_o); end
      checks++; if (empty_o !== 1'b0) begin errors++;
         $display("FAIL reset_empty got %b want 0", empty_o); end
      checks++; if (overflow_err_o !== 1'b0) begin errors++;
         $display("FAIL reset_overflow got %b want 0", overflow_err_o); end
   endtask

   task automatic test_alloc_pair();
      do_reset();
      alloc_req_i = 2'b11;
      #1;
      checks++; if (alloc_gnt_o !== 1'b1) begin errors++;
         $display("FAIL pair_gnt0 got %b want 1", alloc_gnt_o); end
      checks++; if (lane(alloc_preg_o, 0) !== 6'd1 || lane(alloc_preg_o, 1) !== 6'd2) begin
         errors++; $display("FAIL pair_pregs0 got %0d,%0d want 1,2",
                            lane(alloc_preg_o, 0), lane(alloc_preg_o, 1)); end
      tick();
      checks++; if (free_num_o !== 7'd61) begin errors++;
         $display("FAIL pair_free1 got %0d want 61", free_num_o); end
      checks++; if (lane(alloc_preg_o, 0) !== 6'd3 || lane(alloc_preg_o, 1) !== 6'd4) begin
         errors++; $display("FAIL pair_pregs1 got %0d,%0d want 3,4",
                            lane(alloc_preg_o, 0), lane(alloc_preg_o, 1)); end
      checks++; if (full_o !== 1'b0) begin errors++;
         $display("FAIL pair_full got %b want 0", full_o); end
      tick();
      alloc_req_i = 2'b00;
      #1;
      checks++; if (free_num_o !== 7'd59) begin errors++;
         $display("FAIL pair_free2 got %0d want 59", free_num_o); end
   endtask

   task automatic test_sparse_lane();
      do_reset();
      alloc_req_i = 2'b10;
      #1;
      checks++; if (alloc_gnt_o !== 1'b1 || lane(alloc_preg_o, 1) !== 6'd1) begin errors++;
         $display("FAIL sparse_lane1 got gnt=%b preg=%0d want gnt=1 preg=1",
                  alloc_gnt_o, lane(alloc_preg_o, 1)); end
      tick();
      alloc_req_i = 2'b00;
      #1;
      checks++; if (free_num_o !== 7'd62) begin errors++;
         $display("FAIL sparse_free got %0d want 62", free_num_o); end
   endtask

   task automatic test_drain_boundary();
      do_reset();
      for (int i = 0; i < 31; i++) begin
         alloc_req_i = 2'b11;
         tick();
      end
      #1;
      checks++; if (free_num_o !== 7'd1) begin errors++;
         $display("FAIL drain_free1 got %0d want 1", free_num_o); end
      checks++; if (alloc_gnt_o !== 1'b0) begin errors++;
         $display("FAIL drain_no_partial got %b want 0", alloc_gnt_o); end
      tick();
      alloc_req_i = 2'b01;
      #1;
      checks++; if (free_num_o !== 7'd1) begin errors++;
         $display("FAIL drain_hold_free got %0d want 1", free_num_o); end
      checks++; if (alloc_gnt_o !== 1'b1 || lane(alloc_preg_o, 0) !== 6'd63) begin errors++;
         $display("FAIL drain_last got gnt=%b preg=%0d want gnt=1 preg=63",
                  alloc_gnt_o, lane(alloc_preg_o, 0)); end
      tick();
      alloc_req_i = 2'b00;
      #1;
      checks++; if (empty_o !== 1'b1 || free_num_o !== 7'd0) begin errors++;
         $display("FAIL drain_empty got empty=%b free=%0d want 1,0", empty_o, free_num_o); end
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         alloc_req_i = 2'b11;
         tick();
      end
      commit_cnt_i = 2'd2;
      flush_i      = 1'b1;
      #1;
      checks++; if (alloc_gnt_o !== 1'b0) begin errors++;
         $display("FAIL flush_gnt_suppressed got %b want 0", alloc_gnt_o); end
      tick();
      idle();
      #1;
      checks++; if (free_num_o !== 7'd61) begin errors++;
         $display("FAIL flush_free got %0d want 61", free_num_o); end
      alloc_req_i = 2'b11;
      #1;
      checks++; if (alloc_gnt_o !== 1'b1 || lane(alloc_preg_o, 0) !== 6'd3
                    || lane(alloc_preg_o, 1) !== 6'd4) begin errors++;
         $display("FAIL flush_realloc got gnt=%b %0d,%0d want gnt=1 3,4",
                  alloc_gnt_o, lane(alloc_preg_o, 0), lane(alloc_preg_o, 1)); end
      tick();
      idle();
   endtask

   task automatic test_release_after_drain();
      do_reset();
      for (int i = 0; i < 31; i++) begin
         alloc_req_i = 2'b11;
         tick();
      end
      alloc_req_i = 2'b01;
      tick();
      alloc_req_i    = 2'b11;
      release_vld_i  = 2'b11;
      release_preg_i = {6'd9, 6'd5};
      #1;
      checks++; if (alloc_gnt_o !== 1'b0) begin errors++;
         $display("FAIL rel_same_cycle_gnt got %b want 0", alloc_gnt_o); end
      tick();
      release_vld_i = 2'b00;
      #1;
      checks++; if (free_num_o !== 7'd2) begin errors++;
         $display("FAIL rel_free got %0d want 2", free_num_o); end
      checks++; if (alloc_gnt_o !== 1'b1 || lane(alloc_preg_o, 0) !== 6'd5
                    || lane(alloc_preg_o, 1) !== 6'd9) begin errors++;
         $display("FAIL rel_realloc got gnt=%b %0d,%0d want gnt=1 5,9",
                  alloc_gnt_o, lane(alloc_preg_o, 0), lane(alloc_preg_o, 1)); end
      tick();
      // Only lane 1 valid: it must compact into the next slot.
      alloc_req_i    = 2'b00;
      release_vld_i  = 2'b10;
      release_preg_i = {6'd20, 6'd33};
      tick();
      release_vld_i = 2'b00;
      alloc_req_i   = 2'b01;
      #1;
      checks++; if (alloc_gnt_o !== 1'b1 || lane(alloc_preg_o, 0) !== 6'd20) begin errors++;
         $display("FAIL rel_compact got gnt=%b preg=%0d want gnt=1 preg=20",
                  alloc_gnt_o, lane(alloc_preg_o, 0)); end
      tick();
      idle();
   endtask

   task automatic test_overflow_and_reset();
      do_reset();
      release_vld_i  = 2'b01;
      release_preg_i = {6'd0, 6'd7};
      tick();
      idle();
      #1;
      checks++; if (overflow_err_o !== 1'b1) begin errors++;
         $display("FAIL ovf_set got %b want 1", overflow_err_o); end
      checks++; if (free_num_o !== 7'd63) begin errors++;
         $display("FAIL ovf_free got %0d want 63", free_num_o); end
      for (int i = 0; i < 3; i++) tick();
      alloc_req_i = 2'b11;
      tick();
      alloc_req_i = 2'b00;
      #1;
      checks++; if (overflow_err_o !== 1'b1) begin errors++;
         $display("FAIL ovf_sticky got %b want 1", overflow_err_o); end
      do_reset();
      alloc_req_i = 2'b11;
      #1;
      checks++; if (overflow_err_o !== 1'b0) begin errors++;
         $display("FAIL ovf_cleared got %b want 0", overflow_err_o); end
      checks++; if (lane(alloc_preg_o, 0) !== 6'd1 || lane(alloc_preg_o, 1) !== 6'd2) begin
         errors++; $display("FAIL ovf_reset_image got %0d,%0d want 1,2",
                            lane(alloc_preg_o, 0), lane(alloc_preg_o, 1)); end
      idle();
   endtask

   initial begin
      rst = 1'b0;
      idle();
      test_reset();
      test_alloc_pair();
      test_sparse_lane();
      test_drain_boundary();
      test_flush();
      test_release_after_drain();
      test_overflow_and_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
